up_down_counter_checker: RTL and testbench
==========================================

Name: up_down_counter_checker

Overview:
- Hardware self-checker that sits beside an 8-bit loadable up/down counter instance in the counter subsystem.
- Observes the same control inputs the counter sees (Enable, Load, UpDown, In_Data) and the counter's Out_Data.
- Runs an independent prediction model and compares the prediction against Out_Data every cycle.
- Reports per-cycle mismatch pulses, a saturating error count and first-error capture, for use by the UVM scoreboard and by on-chip status registers.

Parameters:
- WIDTH, 8, width of counter data, load data and prediction.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- Clk  input  1  clock, shared with the monitored counter.
- Reset  input  1  synchronous, active-high reset. Shared with the monitored counter, so after Reset the counter value is 0.
- Chk_Enable  input  1  checker enable. Low forces IDLE.
- Clear_Errors  input  1  synchronous clear of error status.
- Mon_Enable  input  1  counter Enable as seen at the counter pin.
- Mon_Load  input  1  counter Load as seen at the counter pin.
- Mon_UpDown  input  1  counter UpDown as seen at the counter pin.
- Mon_In_Data  input  WIDTH  counter load data.
- Mon_Out_Data  input  WIDTH  counter output.
- Mismatch  output  1  one-cycle pulse per detected miscompare.
- Sticky_Error  output  1  set on first miscompare; held until Clear_Errors or Reset.
- Err_Count  output  ERR_CNT_W  saturating count of miscompares.
- First_Exp  output  WIDTH  predicted value at the first miscompare.
- First_Act  output  WIDTH  observed value at the first miscompare.
- Chk_State  output  2  current state (IDLE=0, SYNC=1, CHECK=2).

Behaviour:
- Reset (Reset=1 at a posedge):
  - State becomes IDLE.
  - pred=0.
  - Mismatch, Sticky_Error, Err_Count, First_Exp and First_Act all become 0.
  - Reset overrides every other input.
- Prediction function next(v, en, ld, ud, d), evaluated in priority order:
  1. en&ld gives d.
  2. en&ud gives v+1 mod 2^WIDTH (0xFF to 0x00).
  3. en&!ud gives v-1 mod 2^WIDTH (0x00 to 0xFF).
  4. Otherwise v (hold).
  - Load has priority over count direction. With en=0, Load and UpDown are ignored.
- Controls sampled at posedge N determine the Out_Data visible after posedge N. Out_Data is therefore compared at posedge N+1.
- State machine, evaluated at each posedge without Reset:
  - IDLE: no compare; pred holds. If Chk_Enable=1, go to SYNC.
  - SYNC: pred <= next(Mon_Out_Data, Mon_Enable, Mon_Load, Mon_UpDown, Mon_In_Data), which seeds the model from the observed value. Go to CHECK. No compare in this cycle.
  - CHECK:
    - miscompare = (Mon_Out_Data != pred).
    - pred <= next(pred, controls). The model never re-seeds from the observed value, so a faulty counter is not allowed to self-heal.
    - Remain in CHECK.
  - Any state with Chk_Enable=0 goes to IDLE at the next posedge. In that cycle no compare is done. Error status is retained.
- Mismatch is registered: high during the cycle after the posedge that detected the miscompare. Back-to-back miscompares give a continuous high level.
- On a miscompare:
  - Err_Count increments and saturates at 2^ERR_CNT_W-1.
  - If Sticky_Error=0: First_Exp<=pred, First_Act<=Mon_Out_Data, Sticky_Error<=1.
  - Later miscompares do not overwrite First_Exp or First_Act.
- Clear_Errors=1 at a posedge:
  - Err_Count, Sticky_Error, First_Exp and First_Act are cleared.
  - If a miscompare occurs in the same cycle, the miscompare wins: Err_Count=1, Sticky_Error=1, and the first-capture fields take the new values.
  - Clear_Errors does not affect state or pred.
- Reset while in CHECK: the checker returns to IDLE. It re-enters CHECK only via SYNC, two posedges after Reset deasserts, provided Chk_Enable=1.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package up_down_counter_chk_pkg contains:
  - chk_state_e enum (IDLE, SYNC, CHECK).
  - Function next_count(v, en, ld, ud, d), shared with the UVM reference model.
  - Default WIDTH and ERR_CNT_W constants.
- One sub-module: counter_err_log. It holds Err_Count saturation, Sticky_Error, first-capture and Clear_Errors priority. Inputs are miscompare, pred and act.

Test Plan:
- Reset, then Chk_Enable=1 with a correct counter doing Load 0x10 followed by 5 up-counts -> Chk_State goes IDLE, SYNC, CHECK; Mismatch never asserted; Err_Count=0.
- Correct counter at 0xFF counting up, then down from 0x00 -> wrap to 0x00 and to 0xFF with no Mismatch.
- Force Mon_Out_Data to 0x22 when 0x21 is predicted -> Mismatch pulses once, one cycle after the compare edge; First_Exp=0x21, First_Act=0x22, Err_Count=1. The following cycle still predicts 0x22 (up), so Mismatch stays low if the counter then tracks the model.
- Mon_Enable=1 with Mon_Load=1 and Mon_UpDown=0, data 0x80 -> pred 0x80, not 0x7F; a counter decrementing instead produces exactly one Mismatch.
- Inject persistent miscompares with ERR_CNT_W overridden to 2 -> Err_Count saturates at 3. Clear_Errors asserted on the same edge as a miscompare -> Err_Count=1 and Sticky_Error=1.
- Reset asserted mid-CHECK for one cycle, with Chk_Enable held at 1 -> IDLE, then SYNC, then CHECK; pred reseeds to 0; error status is cleared by Reset.

Source files
------------

// File: rtl/up_down_counter_chk_pkg.sv
// Shared types and the counter prediction function for the up/down counter checker.
// next_count is also used by the UVM reference model, so keep it width-agnostic.
package up_down_counter_chk_pkg;

    localparam int unsigned DefWidth   = 8;
    localparam int unsigned DefErrCntW = 16;
    localparam int unsigned MaxWidth   = 32;

    typedef enum logic [1:0] {
        ChkIdle  = 2'd0,
        ChkSync  = 2'd1,
        ChkCheck = 2'd2
    } chk_state_e;

    // Works in a 32-bit container; callers truncate to their width, which gives mod-2^WIDTH wrap.
    function automatic logic [MaxWidth-1:0] next_count(input logic [MaxWidth-1:0] v,
                                                       input logic en,
                                                       input logic ld,
                                                       input logic ud,
                                                       input logic [MaxWidth-1:0] d);
        logic [MaxWidth-1:0] r;
        r = v;
        if (en && ld) begin
            r = d;
        end else if (en && ud) begin
            r = v + 32'd1;
        end else if (en) begin
            r = v - 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/up_down_counter_checker_if.sv
// Monitor tap on the pins of one up/down counter instance.
interface up_down_counter_checker_if #(
    parameter int unsigned WIDTH = 8
);
    logic             Mon_Enable;
    logic             Mon_Load;
    logic             Mon_UpDown;
    logic [WIDTH-1:0] Mon_In_Data;
    logic [WIDTH-1:0] Mon_Out_Data;

    modport master (
        output Mon_Enable, Mon_Load, Mon_UpDown, Mon_In_Data, Mon_Out_Data
    );

    modport slave (
        input Mon_Enable, Mon_Load, Mon_UpDown, Mon_In_Data, Mon_Out_Data
    );
endinterface

// File: rtl/counter_err_log.sv
// Error status for the counter checker: saturating miscompare count, sticky flag and
// first-miscompare capture, with Clear_Errors losing to a same-cycle miscompare.
module counter_err_log #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Clear_Errors,
    input  logic                 miscompare,
    input  logic [WIDTH-1:0]     pred,
    input  logic [WIDTH-1:0]     act,
    output logic                 Sticky_Error,
    output logic [ERR_CNT_W-1:0] Err_Count,
    output logic [WIDTH-1:0]     First_Exp,
    output logic [WIDTH-1:0]     First_Act
);

    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [WIDTH-1:0]     act_q, act_d;

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        act_d    = act_q;
        if (Clear_Errors) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
            exp_d    = '0;
            act_d    = '0;
        end
        // Applied on top of the clear so a coincident miscompare is recorded as the first one.
        if (miscompare) begin
            if (cnt_d != '1) begin
                cnt_d = cnt_d + ERR_CNT_W'(1);
            end
            if (!sticky_d) begin
                sticky_d = 1'b1;
                exp_d    = pred;
                act_d    = act;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            act_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            act_q    <= act_d;
        end
    end

    assign Sticky_Error = sticky_q;
    assign Err_Count    = cnt_q;
    assign First_Exp    = exp_q;
    assign First_Act    = act_q;

endmodule

// File: rtl/up_down_counter_checker.sv
// Self-checker for an 8-bit loadable up/down counter: seeds a prediction from the observed
// value once, then free-runs the model and flags every cycle where Out_Data disagrees.
module up_down_counter_checker
    import up_down_counter_chk_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned ERR_CNT_W = DefErrCntW
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Chk_Enable,
    input  logic                     Clear_Errors,
    up_down_counter_checker_if.slave mon,
    output logic                     Mismatch,
    output logic                     Sticky_Error,
    output logic [ERR_CNT_W-1:0]     Err_Count,
    output logic [WIDTH-1:0]         First_Exp,
    output logic [WIDTH-1:0]         First_Act,
    output logic [1:0]               Chk_State
);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] pred_q, pred_d;
    logic             mismatch_q;
    logic             miscompare;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] in_data;

    assign out_data = mon.Mon_Out_Data;
    assign in_data  = mon.Mon_In_Data;

    always_comb begin
        state_d    = state_q;
        pred_d     = pred_q;
        miscompare = 1'b0;
        if (!Chk_Enable) begin
            state_d = ChkIdle;
        end else begin
            unique case (state_q)
                ChkIdle: state_d = ChkSync;
                ChkSync: begin
                    pred_d  = WIDTH'(next_count(MaxWidth'(out_data), mon.Mon_Enable,
                                                mon.Mon_Load, mon.Mon_UpDown,
                                                MaxWidth'(in_data)));
                    state_d = ChkCheck;
                end
                ChkCheck: begin
                    // Never reseed from the observed value: a faulty counter must not self-heal.
                    miscompare = (out_data != pred_q);
                    pred_d     = WIDTH'(next_count(MaxWidth'(pred_q), mon.Mon_Enable,
                                                   mon.Mon_Load, mon.Mon_UpDown,
                                                   MaxWidth'(in_data)));
                end
                default: state_d = ChkIdle;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ChkIdle;
            pred_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pred_q     <= pred_d;
            mismatch_q <= miscompare;
        end
    end

    counter_err_log #(
        .WIDTH     (WIDTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_log (
        .Clk          (Clk),
        .Reset        (Reset),
        .Clear_Errors (Clear_Errors),
        .miscompare   (miscompare),
        .pred         (pred_q),
        .act          (out_data),
        .Sticky_Error (Sticky_Error),
        .Err_Count    (Err_Count),
        .First_Exp    (First_Exp),
        .First_Act    (First_Act)
    );

    assign Mismatch  = mismatch_q;
    assign Chk_State = state_q;

endmodule

// File: tb/tb_up_down_counter_checker.sv
// Bench for up_down_counter_checker: an ideal counter with override-based fault injection
// feeds two checkers (default and 2-bit error count) compared against a behavioural model.
module tb_up_down_counter_checker;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset, Chk_Enable, Clear_Errors;

    logic        mm_a, st_a, mm_b, st_b;
    logic [15:0] ec_a;
    logic [1:0]  ec_b;
    logic [7:0]  fe_a, fa_a, fe_b, fa_b;
    logic [1:0]  cs_a, cs_b;

    up_down_counter_checker_if #(.WIDTH(8)) mon_if ();

    up_down_counter_checker dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Chk_Enable   (Chk_Enable),
        .Clear_Errors (Clear_Errors),
        .mon          (mon_if),
        .Mismatch     (mm_a),
        .Sticky_Error (st_a),
        .Err_Count    (ec_a),
        .First_Exp    (fe_a),
        .First_Act    (fa_a),
        .Chk_State    (cs_a)
    );

    up_down_counter_checker #(.WIDTH(8), .ERR_CNT_W(2)) dut_small (
        .Clk          (Clk),
        .Reset        (Reset),
        .Chk_Enable   (Chk_Enable),
        .Clear_Errors (Clear_Errors),
        .mon          (mon_if),
        .Mismatch     (mm_b),
        .Sticky_Error (st_b),
        .Err_Count    (ec_b),
        .First_Exp    (fe_b),
        .First_Act    (fa_b),
        .Chk_State    (cs_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0/1/2 = idle/sync/check, plus an ideal counter value.
    int m_phase, m_pred, m_errs, m_fe, m_fa, cnt;
    bit m_mm, m_sticky;
    bit ovr_en;
    int ovr_val;

    function automatic int nxt(int v, bit en, bit ld, bit ud, int d);
        if (en && ld) return d;
        if (en) return ud ? (v + 1) % 256 : (v + 255) % 256;
        return v;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctrl(bit en, bit ld, bit ud, int d);
        mon_if.Mon_Enable  = en;
        mon_if.Mon_Load    = ld;
        mon_if.Mon_UpDown  = ud;
        mon_if.Mon_In_Data = 8'(d);
    endtask

    task automatic cycle();
        int out, old_pred;
        bit miss, en, ld, ud;
        int d;
        out = ovr_en ? ovr_val : cnt;
        mon_if.Mon_Out_Data = 8'(out);
        @(posedge Clk);
        en = mon_if.Mon_Enable;
        ld = mon_if.Mon_Load;
        ud = mon_if.Mon_UpDown;
        d  = int'(mon_if.Mon_In_Data);
        if (Reset) begin
            m_phase = 0; m_pred = 0; m_mm = 0; m_errs = 0;
            m_sticky = 0; m_fe = 0; m_fa = 0; cnt = 0;
        end else begin
            miss = (m_phase == 2) && Chk_Enable && (out != m_pred);
            old_pred = m_pred;
            if (!Chk_Enable) m_phase = 0;
            else if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1) begin
                m_pred = nxt(out, en, ld, ud, d);
                m_phase = 2;
            end else m_pred = nxt(m_pred, en, ld, ud, d);
            if (Clear_Errors) begin
                m_errs = 0; m_sticky = 0; m_fe = 0; m_fa = 0;
            end
            if (miss) begin
                m_errs++;
                if (!m_sticky) begin
                    m_fe = old_pred; m_fa = out; m_sticky = 1;
                end
            end
            m_mm = miss;
            cnt = nxt(cnt, en, ld, ud, d);
        end
        #1;
        check("state",       32'(cs_a), 32'(m_phase));
        check("mismatch",    32'(mm_a), 32'(m_mm));
        check("sticky",      32'(st_a), 32'(m_sticky));
        check("err_count",   32'(ec_a), 32'(m_errs > 65535 ? 65535 : m_errs));
        check("first_exp",   32'(fe_a), 32'(m_fe));
        check("first_act",   32'(fa_a), 32'(m_fa));
        check("err_count_w2", 32'(ec_b), 32'(m_errs > 3 ? 3 : m_errs));
        check("mismatch_w2", 32'(mm_b), 32'(m_mm));
    endtask

    initial begin
        int old;
        Reset = 1'b1; Chk_Enable = 1'b0; Clear_Errors = 1'b0;
        ovr_en = 0; ovr_val = 0; cnt = 0;
        m_phase = 0; m_pred = 0; m_errs = 0; m_fe = 0; m_fa = 0; m_mm = 0; m_sticky = 0;
        ctrl(0, 0, 0, 0);
        cycle(); cycle();

        // Enable with a healthy counter: load 0x10 then count up.
        Reset = 1'b0; Chk_Enable = 1'b1;
        ctrl(1, 1, 0, 8'h10); cycle();
        check("sync_state", 32'(cs_a), 32'd1);
        ctrl(1, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle();
        check("check_state", 32'(cs_a), 32'd2);
        check("no_err_yet", 32'(ec_a), 32'd0);

        // Wrap up through 0xFF and down through 0x00.
        ctrl(1, 1, 0, 8'hFF); cycle();
        ctrl(1, 0, 1, 0); cycle();
        ctrl(1, 0, 0, 0); cycle(); cycle(); cycle();
        check("wrap_clean", 32'(ec_a), 32'd0);

        // Single corrupted sample: 0x22 shown where 0x21 is predicted.
        ctrl(1, 1, 0, 8'h20); cycle();
        ctrl(1, 0, 1, 0); cycle();
        ovr_en = 1; ovr_val = 8'h22; cycle();
        ovr_en = 0; cycle();
        check("pulse_mm", 32'(mm_a), 32'd0);
        check("first_exp_21", 32'(fe_a), 32'h21);
        check("first_act_22", 32'(fa_a), 32'h22);
        cycle();

        // Load beats down-count; a counter that decrements instead is caught once.
        Clear_Errors = 1'b1; cycle(); Clear_Errors = 1'b0;
        old = cnt;
        ctrl(1, 1, 0, 8'h80); cycle();
        ovr_en = 1; ovr_val = (old + 255) % 256;
        ctrl(1, 0, 1, 0); cycle();
        ovr_en = 0; cycle(); cycle();
        check("load_prio_exp", 32'(fe_a), 32'h80);
        check("load_prio_cnt", 32'(ec_a), 32'd1);

        // Persistent corruption saturates the 2-bit counter; clear coincident with a miss.
        ovr_en = 1;
        for (int i = 0; i < 5; i++) begin
            ovr_val = cnt ^ 1; cycle();
        end
        check("sat_w2", 32'(ec_b), 32'd3);
        ovr_val = cnt ^ 1; Clear_Errors = 1'b1; cycle();
        Clear_Errors = 1'b0; ovr_en = 0;
        check("clr_vs_miss_cnt", 32'(ec_a), 32'd1);
        check("clr_vs_miss_sticky", 32'(st_a), 32'd1);

        // One-cycle Reset mid-CHECK with the checker still enabled.
        Reset = 1'b1; cycle(); Reset = 1'b0;
        check("rst_idle", 32'(cs_a), 32'd0);
        check("rst_clears", 32'(ec_a), 32'd0);
        cycle(); check("rst_sync", 32'(cs_a), 32'd1);
        cycle(); check("rst_check", 32'(cs_a), 32'd2);
        cycle(); cycle();

        // Randomized traffic with sporadic faults, clears, disables and resets.
        for (int i = 0; i < 400; i++) begin
            ctrl($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
            Chk_Enable   = ($urandom_range(0, 31) != 0);
            Clear_Errors = ($urandom_range(0, 31) == 0);
            Reset        = ($urandom_range(0, 63) == 0);
            ovr_en       = ($urandom_range(0, 15) == 0);
            ovr_val      = int'($urandom_range(0, 255));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
